// File: rtl/cti8_alu_pkg.sv
// Shared definitions for the 8-bit ALU and the multi-byte sequencer that drives it:
// opcode values, sequencer state encoding and small helpers.
package cti8_alu_pkg;

  // ALU opcodes
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ROL1 = 4'h5;
  localparam logic [3:0] OP_ROR1 = 4'h6;
  localparam logic [3:0] OP_INC  = 4'h7;
  localparam logic [3:0] OP_DEC  = 4'h8;
  localparam logic [3:0] OP_CPL  = 4'h9;
  localparam logic [3:0] OP_SWAP = 4'hA;
  localparam logic [3:0] OP_PASS = 4'hB;
  localparam logic [3:0] OP_DAA  = 4'hC;
  localparam logic [3:0] OP_DAAS = 4'hD;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Only the carry-chaining opcodes make sense across several bytes
  function automatic logic seq_supported(input logic [3:0] code);
    return (code == OP_ADD) || (code == OP_SUB) ||
           (code == OP_ROL1) || (code == OP_ROR1);
  endfunction

  // Pick little-endian byte 'sel' out of a 32-bit word
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] sel);
    return word[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Multi-byte sequencer: walks a 1-4 byte operation through an external
// combinational 8-bit ALU one byte per cycle, chaining the carry between bytes.
module alu_seq
  import cti8_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [1:0]  len,
  input  logic        cin,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_cin,
  output logic        alu_hc,
  output logic        alu_oe,
  input  logic [7:0]  alu_result,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_h,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flag_h,
  output logic        flag_z,
  output logic        flag_n
);

  seq_state_t  state;
  logic [3:0]  op_q;
  logic [1:0]  len_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic        carry;
  logic [1:0]  idx;

  logic        run;
  logic        is_shift;
  logic        last_byte;
  logic [31:0] res_next;

  assign run      = (state == ST_RUN);
  assign is_shift = (op_q == OP_ROL1) || (op_q == OP_ROR1);
  // ROR1 walks from the top byte down, everything else from byte 0 up
  assign last_byte = (op_q == OP_ROR1) ? (idx == 2'd0) : (idx == len_q);

  // ALU drive is only live while running; shifts take no second operand
  assign alu_a   = run ? byte_of(opa_q, idx) : 8'h00;
  assign alu_b   = (run && !is_shift) ? byte_of(opb_q, idx) : 8'h00;
  assign alu_op  = run ? op_q : 4'h0;
  assign alu_cin = run & carry;
  assign alu_hc  = 1'b0;
  assign alu_oe  = run;

  // Result as it will look once the current ALU byte is written back
  always_comb begin
    res_next = result;
    res_next[{idx, 3'b000} +: 8] = alu_result;
  end

  // Sequencer FSM with registered status, result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= 4'h0;
      len_q  <= 2'd0;
      opa_q  <= 32'h0;
      opb_q  <= 32'h0;
      carry  <= 1'b0;
      idx    <= 2'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= 32'h0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      flag_h <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (seq_supported(op)) begin
              op_q   <= op;
              len_q  <= len;
              opa_q  <= opa;
              opb_q  <= opb;
              carry  <= cin;
              idx    <= (op == OP_ROR1) ? len : 2'd0;
              result <= 32'h0;
              flag_c <= 1'b0;
              flag_v <= 1'b0;
              flag_h <= 1'b0;
              flag_z <= 1'b0;
              flag_n <= 1'b0;
              busy   <= 1'b1;
              state  <= ST_RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          result <= res_next;
          carry  <= alu_c;
          idx    <= (op_q == OP_ROR1) ? (idx - 2'd1) : (idx + 2'd1);
          if (last_byte) begin
            // Bytes above len were cleared at start, so a whole-word test is enough for Z
            flag_c <= alu_c;
            flag_v <= is_shift ? 1'b0 : alu_v;
            flag_h <= is_shift ? 1'b0 : alu_h;
            flag_z <= (res_next == 32'h0);
            flag_n <= res_next[{len_q, 3'b111}];
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq with a behavioural 8-bit ALU attached to the alu_* port.
module tb_alu_seq;
  import cti8_alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [1:0]  len;
  logic        cin;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_op;
  logic        alu_cin;
  logic        alu_hc;
  logic        alu_oe;
  logic [7:0]  alu_result;
  logic        alu_c;
  logic        alu_v;
  logic        alu_h;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;
  logic        flag_c;
  logic        flag_v;
  logic        flag_h;
  logic        flag_z;
  logic        flag_n;

  logic [4:0]  flags;
  assign flags = {flag_c, flag_v, flag_h, flag_z, flag_n};

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  len;
    logic        cin;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] expResult;
    logic [4:0]  expFlags;
  } vec_t;

  vec_t vecs[10];

  alu_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .len(len), .cin(cin),
    .opa(opa), .opb(opb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_hc(alu_hc), .alu_oe(alu_oe),
    .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v), .alu_h(alu_h),
    .busy(busy), .done(done), .err(err), .result(result),
    .flag_c(flag_c), .flag_v(flag_v), .flag_h(flag_h), .flag_z(flag_z), .flag_n(flag_n)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] sumWide;
  logic [4:0] nibSum;
  logic [7:0] bEff;

  // Behavioural 8-bit ALU: ADD/SUB with carry-in (SUB carry = no borrow) and 1-bit rotates through carry
  always_comb begin
    alu_result = 8'h00;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    alu_h      = 1'b0;
    sumWide    = 9'h000;
    nibSum     = 5'h00;
    bEff       = 8'h00;
    case (alu_op)
      OP_ADD, OP_SUB: begin
        bEff       = (alu_op == OP_SUB) ? ~alu_b : alu_b;
        sumWide    = {1'b0, alu_a} + {1'b0, bEff} + {8'h00, alu_cin};
        nibSum     = {1'b0, alu_a[3:0]} + {1'b0, bEff[3:0]} + {4'h0, alu_cin};
        alu_result = sumWide[7:0];
        alu_c      = sumWide[8];
        alu_h      = nibSum[4];
        alu_v      = (alu_a[7] == bEff[7]) && (sumWide[7] != alu_a[7]);
      end
      OP_ROL1: begin
        alu_result = {alu_a[6:0], alu_cin};
        alu_c      = alu_a[7];
      end
      OP_ROR1: begin
        alu_result = {alu_cin, alu_a[7:1]};
        alu_c      = alu_a[0];
      end
      default: begin
        alu_result = 8'h00;
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Runs one vector: start pulse, watch the RUN drive, check latency, result, flags and done pulse
  task automatic applyStimulus(input vec_t v, input int n);
    int cycles;
    bit driveBad;
    logic [7:0] firstA;
    logic [31:0] shifted;
    shifted = v.opa >> (8 * ((v.op == OP_ROR1) ? int'(v.len) : 0));
    firstA  = shifted[7:0];
    driveBad = 1'b0;
    @(negedge clk);
    start = 1'b1; op = v.op; len = v.len; cin = v.cin; opa = v.opa; opb = v.opb;
    tick();
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 12) begin
      if (busy) begin
        if (!alu_oe || alu_hc || alu_op !== v.op) driveBad = 1'b1;
        if ((v.op == OP_ROL1 || v.op == OP_ROR1) && alu_b !== 8'h00) driveBad = 1'b1;
        if (cycles == 1 && (alu_a !== firstA || alu_cin !== v.cin)) driveBad = 1'b1;
      end else begin
        driveBad = 1'b1;
      end
      tick();
      cycles++;
    end
    if (alu_oe || busy || alu_a !== 8'h00 || alu_op !== 4'h0) driveBad = 1'b1;
    checkOutput($sformatf("vec%0d latency", n), 32'(cycles), 32'(int'(v.len) + 2));
    checkOutput($sformatf("vec%0d result", n), result, v.expResult);
    checkOutput($sformatf("vec%0d flags cvhzn", n), 32'(flags), 32'(v.expFlags));
    checkOutput($sformatf("vec%0d alu drive", n), 32'(driveBad), 32'h0);
    tick();
    checkOutput($sformatf("vec%0d done pulse", n), 32'(done), 32'h0);
    checkOutput($sformatf("vec%0d result held", n), result, v.expResult);
  endtask

  initial begin
    int cycles;
    bit doneSeen;

    vecs[0] = '{OP_ADD,  2'd1, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 5'b00000};
    vecs[1] = '{OP_SUB,  2'd3, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b00001};
    vecs[2] = '{OP_ADD,  2'd3, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01101};
    vecs[3] = '{OP_ROL1, 2'd0, 1'b1, 32'h00000081, 32'h00000000, 32'h00000003, 5'b10000};
    vecs[4] = '{OP_ROR1, 2'd1, 1'b0, 32'h00000001, 32'h00000000, 32'h00000000, 5'b10010};
    vecs[5] = '{OP_ROR1, 2'd1, 1'b1, 32'h00000100, 32'h00000000, 32'h00008080, 5'b00001};
    vecs[6] = '{OP_ADD,  2'd0, 1'b0, 32'hFFFFFF10, 32'hAAAAAA20, 32'h00000030, 5'b00000};
    vecs[7] = '{OP_SUB,  2'd1, 1'b1, 32'h00001234, 32'h00001234, 32'h00000000, 5'b10110};
    vecs[8] = '{OP_ROL1, 2'd3, 1'b0, 32'h80000001, 32'hDEADBEEF, 32'h00000002, 5'b10000};
    vecs[9] = '{OP_ADD,  2'd2, 1'b1, 32'h00800000, 32'h00800000, 32'h00000001, 5'b11000};

    rst = 1'b1; start = 1'b0; op = 4'h0; len = 2'd0; cin = 1'b0; opa = 32'h0; opb = 32'h0;
    tick();
    tick();
    checkOutput("reset result", result, 32'h0);
    checkOutput("reset flags", 32'(flags), 32'h0);
    checkOutput("reset status", 32'({busy, done, err}), 32'h0);
    checkOutput("reset alu drive", 32'({alu_oe, alu_hc, alu_cin, alu_op, alu_a, alu_b}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Unsupported opcode: err pulse, stays idle, result and flags of vecs[9] untouched
    @(negedge clk);
    start = 1'b1; op = 4'h2; len = 2'd3; opa = 32'h12345678; opb = 32'h11111111;
    tick();
    start = 1'b0;
    checkOutput("bad op err/busy", 32'({err, busy}), 32'h2);
    tick();
    checkOutput("bad op err pulse", 32'({err, busy}), 32'h0);
    checkOutput("bad op result kept", result, 32'h00000001);
    checkOutput("bad op flags kept", 32'(flags), 32'(5'b11000));

    // start held through RUN and DONE with changed inputs must not disturb the first op
    @(negedge clk);
    start = 1'b1; op = OP_ADD; len = 2'd3; cin = 1'b0; opa = 32'h01020304; opb = 32'h10203040;
    tick();
    op = OP_SUB; opa = 32'hFFFFFFFF; cin = 1'b1;
    cycles = 1;
    while (!done && cycles < 12) begin
      tick();
      cycles++;
    end
    checkOutput("restart latency", 32'(cycles), 32'd5);
    checkOutput("restart result", result, 32'h11223344);
    checkOutput("restart flags", 32'(flags), 32'h0);
    tick();
    start = 1'b0;
    checkOutput("start in DONE ignored", 32'(busy), 32'h0);

    // Reset wins over start in the same cycle
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = OP_ADD; len = 2'd0; opa = 32'h1; opb = 32'h1;
    tick();
    rst = 1'b0; start = 1'b0;
    checkOutput("rst over start busy", 32'(busy), 32'h0);
    checkOutput("rst over start result", result, 32'h0);

    // Reset in the second RUN cycle of a 4-byte ADD discards the operation
    @(negedge clk);
    start = 1'b1; op = OP_ADD; len = 2'd3; cin = 1'b0; opa = 32'h01010101; opb = 32'h01010101;
    tick();
    start = 1'b0;
    tick();
    checkOutput("mid-run busy before rst", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid-run rst status", 32'({busy, done, err, alu_oe}), 32'h0);
    checkOutput("mid-run rst result", result, 32'h0);
    checkOutput("mid-run rst flags", 32'(flags), 32'h0);
    doneSeen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done || busy) doneSeen = 1'b1;
    end
    checkOutput("mid-run rst no done", 32'(doneSeen), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have port start, input, 1 bit: request a multi-byte operation; sampled only in IDLE.
REQ-004 The module SHALL have port op, input, 4 bits: ALU opcode; supported values are ADD 4'h0, SUB 4'h1, ROL1 4'h5 and ROR1 4'h6.
REQ-005 The module SHALL have port len, input, 2 bits: operand length minus one (1-4 bytes).
REQ-006 The module SHALL have port cin, input, 1 bit: initial carry (SUB: 1 = no borrow).
REQ-007 The module SHALL have ports opa and opb, inputs, 32 bits each: operands, little-endian bytes; bytes above len ignored.
REQ-008 The module SHALL have outputs alu_a and alu_b (8 bits each), alu_op (4), alu_cin (1), alu_hc (1) and alu_oe (1): drive the combinational ALU.
REQ-009 The module SHALL have inputs alu_result (8 bits), alu_c, alu_v and alu_h (1 bit each): ALU response, same cycle.
REQ-010 The module SHALL have output busy, 1 bit: high in RUN.
REQ-011 The module SHALL have output done, 1 bit: one-cycle pulse; result and flags valid in that cycle and held until the next start.
REQ-012 The module SHALL have output err, 1 bit: one-cycle pulse on start with an unsupported op.
REQ-013 The module SHALL have output result, 32 bits: result bytes 0..len; higher bytes 0.
REQ-014 The module SHALL have outputs flag_c, flag_v, flag_h, flag_z and flag_n, 1 bit each: final flags.

Function
REQ-015 The state machine SHALL have states IDLE, RUN and DONE; IDLE+start+supported op -> RUN; RUN after last byte -> DONE; DONE -> IDLE unconditionally.
REQ-016 At the start edge the module SHALL latch op, len, opa and opb, load carry <= cin, clear result, and set byte index to 0 (ADD/SUB/ROL1) or len (ROR1).
REQ-017 In each RUN cycle the module SHALL drive alu_a = opa byte[idx], alu_b = opb byte[idx] (0 for ROL1/ROR1), alu_cin = carry, alu_op = latched op, alu_oe = 1 and alu_hc = 0.
REQ-018 At each RUN edge the module SHALL store result byte[idx] <= alu_result and carry <= alu_c, and step idx +1 (ROR1: -1).
REQ-019 Latency SHALL be len+1 RUN cycles followed by 1 DONE cycle, giving done exactly len+2 cycles after the start edge.
REQ-020 Flags SHALL be: flag_c = final carry; flag_v and flag_h = alu_v and alu_h of the last processed byte for ADD/SUB, 0 for ROL1/ROR1; flag_z = (result bytes 0..len all zero); flag_n = bit 7 of byte len.
REQ-021 The module SHALL ignore start in RUN and DONE.
REQ-022 On start with an unsupported op in IDLE, the module SHALL pulse err next cycle, stay in IDLE, and leave result and flags unchanged.
REQ-023 Outside RUN, alu_oe and all alu_* drive outputs SHALL be 0.

Reset
REQ-024 On rst (any state, including mid-RUN) the module SHALL enter IDLE on the next edge and clear all outputs, carry and idx to 0; any in-flight operation is discarded with no done pulse.
REQ-025 rst SHALL take priority over start in the same cycle.

Structure
REQ-026 The ALU opcode localparams (ADD..DAAS, 4'h0..4'hD) and the state encoding SHALL live in a shared package, cti8_alu_pkg.
REQ-027 alu_seq SHALL NOT instantiate the ALU; the top level SHALL connect alu_* to the existing ALU module.
REQ-028 The module SHALL need no sub-module.

Verification
REQ-029 The bench SHALL use the real ALU attached and check done timing (len+2 cycles) in every scenario.
REQ-030 ADD, len=1, opa=0x00FF, opb=0x0001, cin=0 -> result 0x0100, C=0, Z=0, N=0.
REQ-031 SUB, len=3, opa=0, opb=1, cin=1 -> result 0xFFFFFFFF, C=0, N=1, V=0.
REQ-032 ADD, len=3, opa=0x7FFFFFFF, opb=1, cin=0 -> 0x80000000, V=1, N=1, C=0; ROL1, len=0, opa=0x81, cin=1 -> 0x03, C=1.
REQ-033 ROR1, len=1, opa=0x0001, cin=0 -> result 0x0000, C=1, Z=1; ROR1, len=1, opa=0x0100, cin=1 -> 0x8080, C=0.
REQ-034 Start with op=4'h2 -> err pulse, busy stays 0; start during RUN -> ignored; rst asserted in the 2nd RUN cycle of a 4-byte ADD -> IDLE, no done, outputs 0.
